// File: rtl/regfile_write_demux.sv
// y86 register file write side: decodes the write-back destinations into
// per-register enables, holds the registers and publishes them with write flags and a write count.
module regfile_write_demux #(
  parameter int WIDTH = 64,
  parameter int NREG  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [3:0]             dstE,
  input  logic [WIDTH-1:0]       valE,
  input  logic [3:0]             dstM,
  input  logic [WIDTH-1:0]       valM,
  output logic [NREG*WIDTH-1:0]  regs,
  output logic [NREG-1:0]        wr_flags,
  output logic [15:0]            wr_count
);

  logic [NREG-1:0]  en_e;
  logic [NREG-1:0]  en_m;
  logic [NREG-1:0]  wr_flags_next;
  logic [NREG-1:0]  wr_flags_reg;
  logic [15:0]      wr_count_next;
  logic [15:0]      wr_count_reg;
  logic [15:0]      add_cnt;
  logic [WIDTH-1:0] reg_q [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      // RNONE (15) never enables a write, even if NREG were widened to 16.
      assign en_e[gi] = (dstE == 4'(gi)) && (dstE != 4'hF);
      assign en_m[gi] = (dstM == 4'(gi)) && (dstM != 4'hF);

      // valM takes priority on a collision (popq %rsp).
      always_ff @(posedge clk) begin
        if (rst) begin
          reg_q[gi] <= '0;
        end else if (!stall && en_m[gi]) begin
          reg_q[gi] <= valM;
        end else if (!stall && en_e[gi]) begin
          reg_q[gi] <= valE;
        end
      end

      assign regs[gi*WIDTH +: WIDTH] = reg_q[gi];
    end
  endgenerate

  always_comb begin
    wr_flags_next = stall ? '0 : (en_e | en_m);
    add_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      add_cnt = add_cnt + 16'(wr_flags_next[i]);
    end
    wr_count_next = wr_count_reg + add_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_flags_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      wr_flags_reg <= wr_flags_next;
      wr_count_reg <= wr_count_next;
    end
  end

  assign wr_flags = wr_flags_reg;
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_regfile_write_demux.sv
// Directed bench for regfile_write_demux: a vector table plus hand-written
// sequences for mid-stream reset and write-count wrap.
module tb_regfile_write_demux;

  localparam int WIDTH = 64;
  localparam int NREG  = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall;
  logic [3:0]            dstE;
  logic [WIDTH-1:0]      valE;
  logic [3:0]            dstM;
  logic [WIDTH-1:0]      valM;
  logic [NREG*WIDTH-1:0] regs;
  logic [NREG-1:0]       wr_flags;
  logic [15:0]           wr_count;

  int checks   = 0;
  int failures = 0;

  regfile_write_demux #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .dstE     (dstE),
    .valE     (valE),
    .dstM     (dstM),
    .valM     (valM),
    .regs     (regs),
    .wr_flags (wr_flags),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             stall;
    logic [3:0]       de;
    logic [WIDTH-1:0] ve;
    logic [3:0]       dm;
    logic [WIDTH-1:0] vm;
    int               chk;
    logic [WIDTH-1:0] exp_val;
    logic [NREG-1:0]  exp_flags;
    logic [15:0]      exp_count;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [WIDTH-1:0] get_reg(int i);
    return regs[i*WIDTH +: WIDTH];
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] de, input logic [WIDTH-1:0] ve,
                       input logic [3:0] dm, input logic [WIDTH-1:0] vm);
    stall = s;
    dstE  = de;
    valE  = ve;
    dstM  = dm;
    valM  = vm;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic all_zero;

    vecs[0] = '{1'b0, 4'd0,  64'h11,   4'd15, 64'h0,    0,  64'h11,   15'h0001, 16'd1};
    vecs[1] = '{1'b0, 4'd3,  64'hAA,   4'd7,  64'hBB,   3,  64'hAA,   15'h0088, 16'd3};
    vecs[2] = '{1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    7,  64'hBB,   15'h0000, 16'd3};
    vecs[3] = '{1'b0, 4'd4,  64'h100,  4'd4,  64'h200,  4,  64'h200,  15'h0010, 16'd4};
    vecs[4] = '{1'b1, 4'd2,  64'h55,   4'd15, 64'h0,    2,  64'h0,    15'h0000, 16'd4};
    vecs[5] = '{1'b0, 4'd2,  64'h55,   4'd15, 64'h0,    2,  64'h55,   15'h0004, 16'd5};
    vecs[6] = '{1'b0, 4'd15, 64'h0,    4'd14, 64'hDEAD, 14, 64'hDEAD, 15'h4000, 16'd6};
    vecs[7] = '{1'b0, 4'd14, 64'h1,    4'd15, 64'h0,    14, 64'h1,    15'h4000, 16'd7};
    vecs[8] = '{1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    0,  64'h11,   15'h0000, 16'd7};

    rst = 1'b1;
    drive(1'b0, 4'd15, '0, 4'd15, '0);
    edge_step();
    edge_step();
    check("reset_regs", {63'd0, (regs == '0)}, 64'd1);
    check("reset_flags", 64'(wr_flags), 64'h0);
    check("reset_count", 64'(wr_count), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].stall, vecs[i].de, vecs[i].ve, vecs[i].dm, vecs[i].vm);
      edge_step();
      check($sformatf("vec%0d_reg%0d", i, vecs[i].chk), get_reg(vecs[i].chk), vecs[i].exp_val);
      check($sformatf("vec%0d_flags", i), 64'(wr_flags), 64'(vecs[i].exp_flags));
      check($sformatf("vec%0d_count", i), 64'(wr_count), 64'(vecs[i].exp_count));
      $display("vec %0d: stall=%0b dstE=%0d dstM=%0d flags=0x%04h count=%0d",
               i, vecs[i].stall, vecs[i].de, vecs[i].dm, wr_flags, wr_count);
    end
    check("untouched_reg9", get_reg(9), 64'h0);

    // Reset on the same edge as a write: write is dropped.
    rst = 1'b1;
    drive(1'b0, 4'd5, 64'h99, 4'd15, '0);
    edge_step();
    check("midrst_regs_zero", {63'd0, (regs == '0)}, 64'd1);
    check("midrst_flags", 64'(wr_flags), 64'h0);
    check("midrst_count", 64'(wr_count), 64'h0);
    rst = 1'b0;
    edge_step();
    check("postrst_reg5", get_reg(5), 64'h99);
    check("postrst_flags", 64'(wr_flags), 64'h0020);
    check("postrst_count", 64'(wr_count), 64'h1);
    $display("mid-stream reset: reg5=0x%0h count=%0d", get_reg(5), wr_count);

    // Counter wrap: 32767 dual writes reach 0xFFFE.
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    drive(1'b0, 4'd0, 64'h1, 4'd1, 64'h2);
    repeat (32767) @(posedge clk);
    #1;
    check("wrap_preload", 64'(wr_count), 64'hFFFE);
    edge_step();
    check("wrap_dual", 64'(wr_count), 64'h0000);
    check("wrap_dual_flags", 64'(wr_flags), 64'h0003);
    drive(1'b0, 4'd6, 64'h7, 4'd15, '0);
    edge_step();
    check("wrap_single", 64'(wr_count), 64'h0001);
    all_zero = (get_reg(6) == 64'h7) && (get_reg(0) == 64'h1) && (get_reg(1) == 64'h2);
    check("wrap_regs", {63'd0, all_zero}, 64'd1);
    $display("wrap: count=%0d", wr_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
